rr_dispatch: RTL and testbench



---
 rtl/rr_dispatch_pkg.sv | 20 ++
 rtl/rr_dispatch_pick.sv | 28 ++
 rtl/rr_dispatch.sv | 106 ++++++++++
 tb/tb_rr_dispatch.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/rr_dispatch_pkg.sv
// rtl/rr_dispatch_pkg.sv - shared defaults and bit helpers for rr_dispatch (see RR_DISPATCH_STRICT_EN in rr_dispatch.sv)
package rr_dispatch_pkg;

  localparam int DEFAULT_DW = 32;

  // Helpers work on a fixed wide vector; callers zero-extend in and cast back to WIDTH.
  localparam int MAX_WIDTH = 64;
  typedef logic [MAX_WIDTH-1:0] vec_t;

  // Lowest set bit of v as a one-hot vector (zero when v is zero).
  function automatic vec_t onehot_lsb(input vec_t v);
    return v & (~v + vec_t'(1));
  endfunction

  // Bits strictly above the set bit of a one-hot vector (zero for a zero input).
  function automatic vec_t mask_above(input vec_t oh);
    return ~(oh | (oh - vec_t'(1)));
  endfunction

endpackage

// File: rtl/rr_dispatch_pick.sv
// rtl/rr_dispatch_pick.sv - masked lowest-index pick with wrap-around to the unmasked set
module rr_dispatch_pick
  import rr_dispatch_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] can_acc,
  input  logic [WIDTH-1:0] prio_mask,
  output logic [WIDTH-1:0] sel
);

  vec_t masked_x;
  vec_t avail_x;

  // Prefer channels above the last grant; fall back to the lowest free channel.
  always_comb begin
    masked_x = '0;
    avail_x  = '0;
    masked_x[WIDTH-1:0] = can_acc & prio_mask;
    avail_x[WIDTH-1:0]  = can_acc;
    if (|masked_x) begin
      sel = WIDTH'(onehot_lsb(masked_x));
    end else begin
      sel = WIDTH'(onehot_lsb(avail_x));
    end
  end

endmodule

// File: rtl/rr_dispatch.sv
// rtl/rr_dispatch.sv - round-robin dispatcher, one stream to WIDTH registered channels; RR_DISPATCH_STRICT_EN selects strict rotation
module rr_dispatch
  import rr_dispatch_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DW    = DEFAULT_DW
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_vld,
  output logic                in_rdy,
  input  logic [DW-1:0]       in_data,
  output logic [WIDTH-1:0]    out_vld,
  input  logic [WIDTH-1:0]    out_rdy,
  output logic [WIDTH*DW-1:0] out_data,
  output logic [WIDTH-1:0]    out_sel
);

  logic [WIDTH-1:0] can_acc;
  logic [WIDTH-1:0] sel;
  logic             fire;

  // A slot can take a beat when empty or when it is being drained this cycle.
  assign can_acc = ~out_vld | out_rdy;
  assign fire    = in_vld & in_rdy;
  assign out_sel = sel & {WIDTH{fire}};

`ifdef RR_DISPATCH_STRICT_EN

  localparam int PTR_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [PTR_W-1:0] ptr;

  // Target is fixed by the rotation pointer, so beat k always lands on channel k mod WIDTH.
  always_comb begin
    sel      = '0;
    sel[ptr] = 1'b1;
  end

  assign in_rdy = can_acc[ptr];

  // Advance the pointer one channel per accepted beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (fire) begin
      if (ptr == PTR_W'(WIDTH - 1)) begin
        ptr <= '0;
      end else begin
        ptr <= ptr + PTR_W'(1);
      end
    end
  end

`else

  logic [WIDTH-1:0] prio_mask;
  logic [WIDTH-1:0] next_mask;
  vec_t             sel_x;

  rr_dispatch_pick #(
    .WIDTH(WIDTH)
  ) u_pick (
    .can_acc  (can_acc),
    .prio_mask(prio_mask),
    .sel      (sel)
  );

  assign in_rdy = |can_acc;

  // Next search starts just above the channel granted now.
  always_comb begin
    sel_x = '0;
    sel_x[WIDTH-1:0] = sel;
    next_mask = WIDTH'(mask_above(sel_x));
  end

  // Priority mask only moves on an accepted beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      prio_mask <= '1;
    end else if (fire) begin
      prio_mask <= next_mask;
    end
  end

`endif

  // Per-channel output registers: refill on grant, otherwise clear valid once drained.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_vld  <= '0;
      out_data <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (fire && sel[i]) begin
          out_vld[i]           <= 1'b1;
          out_data[i*DW +: DW] <= in_data;
        end else if (out_rdy[i]) begin
          out_vld[i] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_rr_dispatch.sv
// tb/tb_rr_dispatch.sv - scoreboard bench for rr_dispatch (directed vectors, both RR_DISPATCH_STRICT_EN builds)
module tb_rr_dispatch;

  localparam int W  = 4;
  localparam int DW = 32;

  logic            clk;
  logic            rst;
  logic            in_vld;
  logic            in_rdy;
  logic [DW-1:0]   in_data;
  logic [W-1:0]    out_vld;
  logic [W-1:0]    out_rdy;
  logic [W*DW-1:0] out_data;
  logic [W-1:0]    out_sel;

  typedef struct packed {
    logic [1:0]    ch;
    logic [DW-1:0] data;
  } exp_t;

  exp_t sb[$];
  int   n_total = 0;
  int   n_pass  = 0;

  rr_dispatch #(
    .WIDTH(W),
    .DW   (DW)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .in_vld  (in_vld),
    .in_rdy  (in_rdy),
    .in_data (in_data),
    .out_vld (out_vld),
    .out_rdy (out_rdy),
    .out_data(out_data),
    .out_sel (out_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every downstream handshake pops the oldest expected beat for that channel.
  always @(negedge clk) begin
    if (!rst) begin
      for (int c = 0; c < W; c++) begin
        if (out_vld[c] && out_rdy[c]) begin
          int idx;
          idx = -1;
          for (int j = 0; j < sb.size(); j++) begin
            if (idx < 0 && int'(sb[j].ch) == c) idx = j;
          end
          if (idx < 0) begin
            n_total++;
            $display("FAIL unexpected_beat ch%0d: got %0h expected no beat", c, out_data[c*DW +: DW]);
          end else begin
            check($sformatf("ch%0d_data", c), 128'(out_data[c*DW +: DW]), 128'(sb[idx].data));
            sb.delete(idx);
          end
        end
      end
    end
  end

  // Offer one beat, check it is accepted on the expected channel, and record it.
  task automatic send(input logic [DW-1:0] d, input int ch);
    @(posedge clk); #1;
    in_vld  = 1'b1;
    in_data = d;
    #1;
    check($sformatf("in_rdy_%0h", d), 128'(in_rdy), 128'(1));
    check($sformatf("out_sel_%0h", d), 128'(out_sel), 128'(4'b0001 << ch));
    sb.push_back('{ch: 2'(ch), data: d});
  endtask

  task automatic idle(input int n);
    @(posedge clk); #1;
    in_vld = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst     = 1'b1;
    in_vld  = 1'b0;
    in_data = '0;
    out_rdy = '0;
    @(posedge clk); @(posedge clk); #1;
    check("reset_out_vld", 128'(out_vld), 128'(0));
    check("reset_out_data", 128'(out_data), 128'(0));
    check("reset_out_sel", 128'(out_sel), 128'(0));
    rst = 1'b0;
    #1;
    check("reset_in_rdy", 128'(in_rdy), 128'(1));

    // Continuous stream, all consumers ready: ch0,1,2,3,0,1,2,3 with one-cycle latency.
    out_rdy = 4'hF;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      check($sformatf("stream_out_vld_%0d", k), 128'(out_vld),
            (k == 0) ? 128'(0) : 128'(4'b0001 << ((k - 1) % 4)));
      in_vld  = 1'b1;
      in_data = 32'hA0 + 32'(k);
      #1;
      check($sformatf("stream_in_rdy_%0d", k), 128'(in_rdy), 128'(1));
      check($sformatf("stream_out_sel_%0d", k), 128'(out_sel), 128'(4'b0001 << (k % 4)));
      sb.push_back('{ch: 2'(k % 4), data: 32'hA0 + 32'(k)});
    end
    @(posedge clk); #1;
    in_vld = 1'b0;
    check("stream_last_vld", 128'(out_vld), 128'(4'b1000));
    @(posedge clk); #1;

    // All consumers stalled: four beats fill the slots, the fifth is refused.
    out_rdy = 4'h0;
    for (int k = 0; k < 4; k++) send(32'hB0 + 32'(k), k);
    @(posedge clk); #1;
    in_data = 32'hB4;
    #1;
    check("stall_in_rdy", 128'(in_rdy), 128'(0));
    check("stall_out_sel", 128'(out_sel), 128'(0));
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      check($sformatf("stall_hold_vld_%0d", k), 128'(out_vld), 128'(4'hF));
      check($sformatf("stall_hold_data_%0d", k), 128'(out_data),
            128'({32'hB3, 32'hB2, 32'hB1, 32'hB0}));
    end
    in_vld  = 1'b0;
    out_rdy = 4'hF;
    @(posedge clk); #1;
    check("stall_drained", 128'(out_vld), 128'(0));

`ifndef RR_DISPATCH_STRICT_EN
    // ch2 stuck: rotation skips it (0,1,2,3,0,1 then 3,0).
    out_rdy = 4'b1011;
    send(32'hC0, 0); send(32'hC1, 1); send(32'hC2, 2); send(32'hC3, 3);
    send(32'hC4, 0); send(32'hC5, 1); send(32'hC6, 3); send(32'hC7, 0);
    @(posedge clk); #1;
    in_vld = 1'b0;
    check("skip_ch2_held", 128'(out_data[2*DW +: DW]), 128'(32'hC2));
    out_rdy = 4'hF;
    idle(2);

    // Same-cycle drain and refill of ch1.
    out_rdy = 4'h0;
    send(32'hE1, 1); send(32'hE2, 2); send(32'hE3, 3); send(32'hE4, 0);
    @(posedge clk); #1;
    out_rdy = 4'b0010;
    in_data = 32'h55;
    #1;
    check("refill_in_rdy", 128'(in_rdy), 128'(1));
    check("refill_out_sel", 128'(out_sel), 128'(4'b0010));
    sb.push_back('{ch: 2'd1, data: 32'h55});
    @(posedge clk); #1;
    in_vld  = 1'b0;
    out_rdy = 4'h0;
    check("refill_vld", 128'(out_vld), 128'(4'hF));
    check("refill_data", 128'(out_data[1*DW +: DW]), 128'(32'h55));
    @(posedge clk); #1;
    check("refill_hold", 128'(out_data[1*DW +: DW]), 128'(32'h55));
    out_rdy = 4'hF;
    idle(2);

    // Reset with every channel full: all beats dropped, rotation restarts at ch0.
    out_rdy = 4'h0;
    send(32'hF0, 2); send(32'hF1, 3); send(32'hF2, 0); send(32'hF3, 1);
    @(posedge clk); #1;
    in_vld = 1'b0;
    check("prereset_full", 128'(out_vld), 128'(4'hF));
    rst = 1'b1;
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("midreset_out_vld", 128'(out_vld), 128'(0));
    check("midreset_out_data", 128'(out_data), 128'(0));
    check("midreset_in_rdy", 128'(in_rdy), 128'(1));
    send(32'h77, 0);
    out_rdy = 4'hF;
    idle(2);
`else
    // Strict rotation: ch1 stalled with pointer at 1 blocks upstream.
    out_rdy = 4'b1101;
    send(32'hD0, 0); send(32'hD1, 1); send(32'hD2, 2); send(32'hD3, 3); send(32'hD4, 0);
    @(posedge clk); #1;
    in_data = 32'hD5;
    #1;
    check("strict_block_in_rdy", 128'(in_rdy), 128'(0));
    check("strict_block_out_sel", 128'(out_sel), 128'(0));
    out_rdy = 4'hF;
    #1;
    check("strict_release_in_rdy", 128'(in_rdy), 128'(1));
    check("strict_release_out_sel", 128'(out_sel), 128'(4'b0010));
    sb.push_back('{ch: 2'd1, data: 32'hD5});
    send(32'hD6, 2);
    idle(2);
`endif

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_empty", 128'(sb.size()), 128'(0));
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
